// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MIPS multiply/divide unit owning the HI/LO registers.
// Executes MULT, MULTU, DIV, DIVU (33-cycle radix-2 iteration) and MTHI/MTLO
// (single-edge register writes). Signed operations iterate on magnitudes and
// apply the result signs in the final FIX cycle.
// Optional build macro: MDU_FAST_MUL_EN -- MULT/MULTU use a single-cycle 32x32
// multiplier and skip the RUN state; division timing is unaffected.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [4:0]  r_cnt;
    logic        r_is_div;   // latched operation class: 1 = divide, 0 = multiply
    logic        r_neg_q;    // product / quotient sign
    logic        r_neg_r;    // remainder sign (dividend sign)
    logic        r_div0;     // divisor was zero at accept
    logic [63:0] r_acc;      // multiply: {partial sum, multiplier}; divide: [31:0] dividend/quotient
    logic [31:0] r_opnd;     // multiplicand or divisor magnitude
    logic [31:0] r_rem;      // partial remainder

    // ---------------------------------------------------------------
    // Operand decode and magnitude conversion at accept
    // ---------------------------------------------------------------
    logic        w_is_arith;
    logic        w_is_signed;
    logic        w_is_div;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_accept;

    assign w_is_arith  = ~op[2];
    assign w_is_signed = ~op[0];
    assign w_is_div    = op[1];
    assign w_neg_a     = w_is_signed & A[31];
    assign w_neg_b     = w_is_signed & B[31];
    assign w_mag_a     = w_neg_a ? (32'd0 - A) : A;
    assign w_mag_b     = w_neg_b ? (32'd0 - B) : B;
    // Cancel has priority over a same-cycle start, so the start is discarded.
    assign w_accept    = (r_state == S_IDLE) & start & ~cancel;

`ifdef MDU_FAST_MUL_EN
    logic [63:0] w_fast_prod;
    assign w_fast_prod = {32'd0, w_mag_a} * {32'd0, w_mag_b};
`endif

    // ---------------------------------------------------------------
    // One iteration step of each algorithm
    // ---------------------------------------------------------------
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic        w_qbit;

    // Shift-add: add the multiplicand to the upper half when the current
    // multiplier bit (LSB of the accumulator) is set, then shift right.
    assign w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    // Restoring divide: bring in the next dividend bit and trial-subtract.
    assign w_div_shift = {r_rem, r_acc[31]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_qbit      = ~w_div_diff[32];

    // ---------------------------------------------------------------
    // Sign fix-up of the final results
    // ---------------------------------------------------------------
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_remd;

    assign w_prod = r_neg_q ? (64'd0 - r_acc) : r_acc;
    assign w_quot = r_div0 ? 32'hFFFF_FFFF
                           : (r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0]);
    assign w_remd = r_neg_r ? (32'd0 - r_rem) : r_rem;

    // Control FSM, iteration datapath and HI/LO registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_cnt    <= 5'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_acc    <= 64'd0;
            r_opnd   <= 32'd0;
            r_rem    <= 32'd0;
        end else begin
            r_done <= 1'b0;
            if (cancel && r_busy) begin
                // Abort: partial result is dropped, HI/LO keep their values.
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            if (w_is_arith) begin
                                r_busy   <= 1'b1;
                                r_cnt    <= 5'd0;
                                r_is_div <= w_is_div;
                                r_neg_q  <= w_neg_a ^ w_neg_b;
                                r_neg_r  <= w_neg_a;
                                r_div0   <= w_is_div & (B == 32'd0);
                                r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
                                r_rem    <= 32'd0;
                                if (w_is_div) begin
                                    r_acc   <= {32'd0, w_mag_a};
                                    r_state <= S_RUN;
                                end else begin
`ifdef MDU_FAST_MUL_EN
                                    r_acc   <= w_fast_prod;
                                    r_state <= S_FIX;
`else
                                    r_acc   <= {32'd0, w_mag_b};
                                    r_state <= S_RUN;
`endif
                                end
                            end else if (op == OP_MTHI) begin
                                r_hi <= A;
                            end else if (op == OP_MTLO) begin
                                r_lo <= A;
                            end
                        end
                    end

                    S_RUN: begin
                        if (r_is_div) begin
                            r_rem        <= w_qbit ? w_div_diff[31:0] : w_div_shift[31:0];
                            r_acc[31:0]  <= {r_acc[30:0], w_qbit};
                        end else begin
                            r_acc <= {w_mul_sum, r_acc[31:1]};
                        end
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_state <= S_FIX;
                        end
                    end

                    S_FIX: begin
                        if (r_is_div) begin
                            r_hi <= w_remd;
                            r_lo <= w_quot;
                        end else begin
                            r_hi <= w_prod[63:32];
                            r_lo <= w_prod[31:0];
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit.
// Honors MDU_FAST_MUL_EN for the expected multiply latency.
module tb_mul_div_unit;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_bad;

    mul_div_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch an arithmetic op, optionally re-assert start at edge E+inj_at,
    // then wait (bounded) for done and check latency and results.
    task automatic do_op(input string tag, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int inj_at, input logic [2:0] inj_op,
                         input logic [31:0] inj_a);
        int          lat;
        logic        early;
        logic [31:0] h0;
        logic [31:0] l0;
        start = 1'b1; op = o; A = a; B = b;
        tick();                                  // accept edge E
        start = 1'b0; op = 3'b110; A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
        check({tag, "_accept_busy"}, 64'(busy), 64'd1);
        check({tag, "_done_low"},    64'(done), 64'd0);
        lat = 0; early = 1'b0; h0 = hi; l0 = lo;
        while (lat < 40) begin
            if (lat + 1 == inj_at) begin
                start = 1'b1; op = inj_op; A = inj_a;
            end
            tick();
            lat++;
            start = 1'b0;
            if (done) break;
            if (hi !== h0 || lo !== l0) early = 1'b1;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check({tag, "_hilo_stable"}, 64'(early), 64'd0);
    endtask

    initial begin
        logic seen_done;
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; start = 1'b0; op = 3'b000; A = 32'd0; B = 32'd0; cancel = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);

        // Back-to-back sequence: each op starts in the cycle done is high.
        do_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT,
              32'hFFFF_FFFE, 32'h0000_0001, -1, 3'b000, 32'd0);
        do_op("mult_neg",  3'b000, 32'hFFFF_FFFD, 32'd7, MUL_LAT,
              32'hFFFF_FFFF, 32'hFFFF_FFEB, -1, 3'b000, 32'd0);
        do_op("div_neg",   3'b010, 32'hFFFF_FFF9, 32'd2, DIV_LAT,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, 3'b000, 32'd0);
        do_op("divu_zero", 3'b011, 32'd100, 32'd0, DIV_LAT,
              32'd100, 32'hFFFF_FFFF, -1, 3'b000, 32'd0);
        do_op("div_ovf",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT,
              32'd0, 32'h8000_0000, -1, 3'b000, 32'd0);
        do_op("div_zero_neg", 3'b010, 32'hFFFF_FFF0, 32'd0, DIV_LAT,
              32'hFFFF_FFF0, 32'hFFFF_FFFF, -1, 3'b000, 32'd0);
        // Start re-asserted at E+5 with MTHI must be dropped.
        do_op("divu_busy_start", 3'b011, 32'd1000, 32'd7, DIV_LAT,
              32'd6, 32'd142, 5, 3'b100, 32'h0000_1234);
        tick();
        check("done_one_cycle", 64'(done), 64'd0);

        // MTHI then a cancelled DIV.
        start = 1'b1; op = 3'b100; A = 32'h0000_AAAA;
        tick();
        start = 1'b0;
        check("mthi_hi",   64'(hi),   64'h0000_AAAA);
        check("mthi_busy", 64'(busy), 64'd0);
        check("mthi_done", 64'(done), 64'd0);
        start = 1'b1; op = 3'b010; A = 32'hFFFF_FF9C; B = 32'd3;
        tick();                                  // accept edge E
        start = 1'b0;
        repeat (10) tick();                      // edges E+1..E+10
        check("cancel_pre_busy", 64'(busy), 64'd1);
        cancel = 1'b1;
        tick();                                  // edge E+11
        cancel = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_done", 64'(done), 64'd0);
        seen_done = 1'b0;
        repeat (40) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        check("cancel_no_done", 64'(seen_done), 64'd0);
        check("cancel_hi_kept", 64'(hi), 64'h0000_AAAA);

        start = 1'b1; op = 3'b101; A = 32'd5;
        tick();
        start = 1'b0;
        check("mtlo_lo",   64'(lo),   64'd5);
        check("mtlo_done", 64'(done), 64'd0);

        // Cancel with start while idle: start discarded.
        start = 1'b1; op = 3'b101; A = 32'd9; cancel = 1'b1;
        tick();
        check("cancel_start_mtlo", 64'(lo), 64'd5);
        op = 3'b011; A = 32'd1; B = 32'd1;
        tick();
        check("cancel_start_div_busy", 64'(busy), 64'd0);
        start = 1'b0; cancel = 1'b0;

        // No-op codes change nothing.
        start = 1'b1; op = 3'b110; A = 32'd77; B = 32'd1;
        tick();
        op = 3'b111;
        tick();
        start = 1'b0;
        check("noop_busy", 64'(busy), 64'd0);
        check("noop_hi",   64'(hi),   64'h0000_AAAA);
        check("noop_lo",   64'(lo),   64'd5);

        // Reset during a MULTU.
        start = 1'b1; op = 3'b001; A = 32'd3; B = 32'd5;
        tick();                                  // edge E
        start = 1'b0;
        repeat (19) tick();                      // edges E+1..E+19
        rst = 1'b1;
        tick();                                  // edge E+20
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi",   64'(hi),   64'd0);
        check("midrst_lo",   64'(lo),   64'd0);
        do_op("multu_after_rst", 3'b001, 32'd3, 32'd4, MUL_LAT,
              32'd0, 32'd12, -1, 3'b000, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
